// File: rtl/onchip_mem_tester_pkg.sv
// Shared types and LFSR definition for the on-chip memory tester.
package onchip_mem_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois step: the bit shifted out of bit 0 feeds the taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/onchip_mem_tester_lfsr32.sv
// 32-bit Galois LFSR pattern source with synchronous load and advance.
module lfsr32
  import onchip_mem_tester_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        value <= 32'h0000_0001;
    else if (load)    value <= (seed == '0) ? 32'h0000_0001 : seed;
    else if (advance) value <= lfsr_next(value);
  end

endmodule

// File: rtl/onchip_mem_tester.sv
// Fills a window of on-chip memory with an LFSR pattern, reads it back and
// reports the number of mismatching words and the first failing address.
module onchip_mem_tester
  import onchip_mem_tester_pkg::*;
#(
  parameter int DEPTH        = 10000,
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DRAIN_LAST = (ADDR_W+1)'(READ_LATENCY - 1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   n_words, idx;
  logic [ADDR_W-1:0] addr, base_q, addr_inc, base_mod;
  logic [ADDR_W:0]   count_clamped;
  logic [31:0]       seed_q, lfsr_seed, lfsr_value;
  logic              lfsr_load, lfsr_adv, last_word;

  logic              exp_v [READ_LATENCY];
  logic [31:0]       exp_d [READ_LATENCY];
  logic [ADDR_W-1:0] exp_a [READ_LATENCY];

  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign pass           = done && (err_count == '0);

  assign count_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  // base_addr is assumed below 2*DEPTH, so one conditional subtract is a full modulo.
  assign base_mod  = ({1'b0, base_addr} >= DEPTH_W) ? ADDR_W'({1'b0, base_addr} - DEPTH_W) : base_addr;
  assign addr_inc  = (addr == ADDR_LAST) ? '0 : addr + ADDR_ONE;
  assign last_word = (idx == n_words - CNT_ONE);
  assign lfsr_seed = (state == IDLE) ? seed : seed_q;

  lfsr32 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (lfsr_seed),
    .value   (lfsr_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    lfsr_load      = 1'b0;
    lfsr_adv       = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        lfsr_load = 1'b1;
        state_nxt = (word_count == '0) ? DONE : FILL;
      end
      FILL: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = addr;
        mem_writedata  = lfsr_value;
        // Last write reloads the seed so the read phase regenerates the same sequence.
        if (last_word) begin
          lfsr_load = 1'b1;
          state_nxt = READ;
        end else begin
          lfsr_adv = 1'b1;
        end
      end
      READ: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_address    = addr;
        lfsr_adv       = 1'b1;
        if (last_word) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (idx == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_words        <= '0;
      idx            <= '0;
      addr           <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        exp_v[i] <= 1'b0;
        exp_d[i] <= '0;
        exp_a[i] <= '0;
      end
    end else begin
      exp_v[0] <= (state == READ);
      exp_d[0] <= lfsr_value;
      exp_a[0] <= addr;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        exp_v[i] <= exp_v[i-1];
        exp_d[i] <= exp_d[i-1];
        exp_a[i] <= exp_a[i-1];
      end

      if (exp_v[READ_LATENCY-1] && (mem_readdata != exp_d[READ_LATENCY-1])) begin
        if (err_count != '1) err_count <= err_count + 16'd1;
        if (err_count == '0) first_err_addr <= exp_a[READ_LATENCY-1];
      end

      unique case (state)
        IDLE: if (start) begin
          n_words        <= count_clamped;
          idx            <= '0;
          addr           <= base_mod;
          base_q         <= base_mod;
          seed_q         <= seed;
          err_count      <= '0;
          first_err_addr <= '0;
        end
        FILL, READ: begin
          if (last_word) begin
            idx  <= '0;
            addr <= base_q;
          end else begin
            idx  <= idx + CNT_ONE;
            addr <= addr_inc;
          end
        end
        DRAIN:   idx <= idx + CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule
